hex_display_controller: RTL and testbench
=========================================

Name: hex_display_controller

Overview:
- Parametrised, clocked successor to the combinational seven-segment output stage of the blackjack game.
- Converts player and dealer hand values to BCD with a sequential double-dabble converter and blanks leading zeros.
- Drives a configurable-width message field that scrolls the title during S_RESET and blinks the result in S_RESULT_*.
- Sits between the game FSM and the board HEX pins.

Parameters:
HAND_W, 5, bit width of each hand value input.
SCORE_DIGITS, 2, seven-segment digits per score field. Elaboration error if 10^SCORE_DIGITS <= 2^HAND_W-1.
MSG_DIGITS, 4, seven-segment digits in the message field. Must be >= 4.
TICK_DIV, 25000000, clock cycles per display tick (scroll step and blink half-period).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
player_value  in  HAND_W  player hand total, unsigned
dealer_value  in  HAND_W  dealer hand total, unsigned
game_state  in  gameState  current game FSM state
hex_player  out  7*SCORE_DIGITS  player score segments, active-low; digit 0 in bits [6:0] is least significant
hex_dealer  out  7*SCORE_DIGITS  dealer score segments, active-low
hex_msg  out  7*MSG_DIGITS  message segments; digit MSG_DIGITS-1 is leftmost
busy  out  1  high while a BCD conversion is in progress

Behaviour:
- Reset (synchronous, active-high):
  - All hex outputs 7'h7F (blank); busy=0; tick counter=0; scroll index=0; blink phase=visible; snapshot-valid flag=0.
  - Reset mid-conversion abandons it; display registers return to blank.
- Character codes are 6-bit: 0x00-0x09 digits, 0x0A-0x23 letters A-Z, 0x3F blank (all segments off).
- Tick generator:
  - Counter runs 0..TICK_DIV-1; tick pulses for one cycle when the counter wraps.
  - Counter clears to 0 whenever the message mode changes, so the first tick after a change comes exactly TICK_DIV cycles later.
- BCD converter (both hands converted in parallel):
  - Starts when idle and either (snapshot-valid=0) or (player_value, dealer_value) differs from the stored snapshot. The start cycle loads the snapshot and shift registers and sets busy=1.
  - Performs HAND_W shift/add-3 cycles, then writes the display registers and clears busy.
  - Latency from an input change to the updated hex_player/hex_dealer is HAND_W+2 cycles.
  - Inputs that change while busy are ignored until completion, then re-compared on the next cycle; the latest value always ends up displayed.
  - Score outputs hold their previous value during conversion, so no intermediate glitch reaches the pins.
- Leading-zero blanking: any zero digit above the most significant nonzero digit shows blank. Digit 0 always shows, so a value of 0 displays as " 0".
- Message FSM, mode selected from game_state (hex_msg updates on the next edge after game_state changes):
  - M_SCROLL (game_state==S_RESET): a ring of "BLACKJACK" followed by MSG_DIGITS blanks is shown through a MSG_DIGITS window; each tick advances it one character left. The index wraps to 0 after the last ring position.
  - M_BLINK (S_RESULT_WIN / S_RESULT_LOSE / S_RESULT_TIE): text "WIN", "LOSE" or "TIE", right-justified and blank-padded on the left. Each tick toggles between text and all-blank; the phase starts visible.
  - M_STATIC (any other state): "PLAY", right-justified, never blinks.
  - On entry to any mode: scroll index=0, blink phase=visible. A change between two result states (e.g. WIN to TIE) counts as a mode re-entry and restarts blinking visible.
- Character-to-segment mapping reuses sevenSegmentDecoder; code 0x3F must map to 7'h7F.

Decomposition:
- Package display_pkg holds:
  - character code constants (CHAR_0..CHAR_Z, CHAR_BLANK);
  - message constants (title ring, WIN, LOSE, TIE, PLAY);
  - msg_mode_t enum {M_STATIC, M_SCROLL, M_BLINK};
  - the segment-blank constant 7'h7F.
- Sub-module bin_to_bcd_seq (parameters IN_W, DIGITS; ports start, value, done, bcd), instantiated twice under one shared controller.

Test Plan:
1. Assert reset for 3 cycles with player_value=0, dealer_value=0 -> all outputs 7'h7F. After release, busy high for 6 cycles; then hex_player and hex_dealer show " 0".
2. player_value 0 -> 21 (HAND_W=5) -> busy asserted, hex_player shows "21" on cycle 7, hex_dealer unchanged. Then 21 -> 7 -> " 7" with the tens digit blank.
3. Change player_value to 17 on cycle 2 of a conversion of 12 -> "12" is displayed first, then a second conversion shows "17" with no other value in between.
4. TICK_DIV=4, game_state=S_RESET, MSG_DIGITS=4 -> hex_msg "BLAC", "LACK", "ACKJ" every 4 cycles. After 13 ticks the window wraps back to "BLAC".
5. TICK_DIV=4, game_state=S_RESULT_LOSE -> "LOSE" for 4 cycles, blank for 4, repeating. Switching to S_RESULT_TIE mid-blank -> " TIE" visible on the next edge.
6. MSG_DIGITS=6, game_state=S_RESULT_WIN -> "   WIN". Reset asserted mid-blink -> all blank on the next edge; after release with game_state=S_RESULT_WIN -> "   WIN" visible.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types, character codes and message constants
// for the blackjack seven-segment display controller.
package display_pkg;

  typedef enum logic [2:0] {
    S_RESET,
    S_DEAL,
    S_PLAYER,
    S_DEALER,
    S_RESULT_WIN,
    S_RESULT_LOSE,
    S_RESULT_TIE
  } gameState;

  typedef enum logic [1:0] {
    M_STATIC,
    M_SCROLL,
    M_BLINK
  } msg_mode_t;

  typedef logic [5:0] char_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam char_t CHAR_0 = 6'h00;
  localparam char_t CHAR_1 = 6'h01;
  localparam char_t CHAR_2 = 6'h02;
  localparam char_t CHAR_3 = 6'h03;
  localparam char_t CHAR_4 = 6'h04;
  localparam char_t CHAR_5 = 6'h05;
  localparam char_t CHAR_6 = 6'h06;
  localparam char_t CHAR_7 = 6'h07;
  localparam char_t CHAR_8 = 6'h08;
  localparam char_t CHAR_9 = 6'h09;
  localparam char_t CHAR_A = 6'h0A;
  localparam char_t CHAR_B = 6'h0B;
  localparam char_t CHAR_C = 6'h0C;
  localparam char_t CHAR_D = 6'h0D;
  localparam char_t CHAR_E = 6'h0E;
  localparam char_t CHAR_F = 6'h0F;
  localparam char_t CHAR_G = 6'h10;
  localparam char_t CHAR_H = 6'h11;
  localparam char_t CHAR_I = 6'h12;
  localparam char_t CHAR_J = 6'h13;
  localparam char_t CHAR_K = 6'h14;
  localparam char_t CHAR_L = 6'h15;
  localparam char_t CHAR_M = 6'h16;
  localparam char_t CHAR_N = 6'h17;
  localparam char_t CHAR_O = 6'h18;
  localparam char_t CHAR_P = 6'h19;
  localparam char_t CHAR_Q = 6'h1A;
  localparam char_t CHAR_R = 6'h1B;
  localparam char_t CHAR_S = 6'h1C;
  localparam char_t CHAR_T = 6'h1D;
  localparam char_t CHAR_U = 6'h1E;
  localparam char_t CHAR_V = 6'h1F;
  localparam char_t CHAR_W = 6'h20;
  localparam char_t CHAR_X = 6'h21;
  localparam char_t CHAR_Y = 6'h22;
  localparam char_t CHAR_Z = 6'h23;
  localparam char_t CHAR_BLANK = 6'h3F;

  localparam int TITLE_LEN = 9;

  localparam char_t [0:TITLE_LEN-1] MSG_TITLE = {
    CHAR_B, CHAR_L, CHAR_A, CHAR_C, CHAR_K,
    CHAR_J, CHAR_A, CHAR_C, CHAR_K
  };

  // Right-justified four-character words; index 0 is the rightmost digit.
  localparam char_t [3:0] MSG_WIN =
    {CHAR_BLANK, CHAR_W, CHAR_I, CHAR_N};
  localparam char_t [3:0] MSG_LOSE =
    {CHAR_L, CHAR_O, CHAR_S, CHAR_E};
  localparam char_t [3:0] MSG_TIE =
    {CHAR_BLANK, CHAR_T, CHAR_I, CHAR_E};
  localparam char_t [3:0] MSG_PLAY =
    {CHAR_P, CHAR_L, CHAR_A, CHAR_Y};

  function automatic logic [6:0] sevenSegmentDecoder(input char_t c);
    logic [6:0] s;
    case (c)
      CHAR_0: s = 7'h40;
      CHAR_1: s = 7'h79;
      CHAR_2: s = 7'h24;
      CHAR_3: s = 7'h30;
      CHAR_4: s = 7'h19;
      CHAR_5: s = 7'h12;
      CHAR_6: s = 7'h02;
      CHAR_7: s = 7'h78;
      CHAR_8: s = 7'h00;
      CHAR_9: s = 7'h10;
      CHAR_A: s = 7'h08;
      CHAR_B: s = 7'h03;
      CHAR_C: s = 7'h46;
      CHAR_D: s = 7'h21;
      CHAR_E: s = 7'h06;
      CHAR_F: s = 7'h0E;
      CHAR_G: s = 7'h42;
      CHAR_H: s = 7'h09;
      CHAR_I: s = 7'h4F;
      CHAR_J: s = 7'h61;
      CHAR_K: s = 7'h0A;
      CHAR_L: s = 7'h47;
      CHAR_M: s = 7'h6A;
      CHAR_N: s = 7'h2B;
      CHAR_O: s = 7'h40;
      CHAR_P: s = 7'h0C;
      CHAR_Q: s = 7'h18;
      CHAR_R: s = 7'h2F;
      CHAR_S: s = 7'h12;
      CHAR_T: s = 7'h07;
      CHAR_U: s = 7'h41;
      CHAR_V: s = 7'h63;
      CHAR_W: s = 7'h55;
      CHAR_X: s = 7'h09;
      CHAR_Y: s = 7'h11;
      CHAR_Z: s = 7'h24;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic char_t titleChar(input int r);
    if (r < TITLE_LEN) return MSG_TITLE[r];
    return CHAR_BLANK;
  endfunction

  function automatic longint pow10(input int n);
    longint p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one shift/add-3 step per
// cycle after start, done pulses once the last step has landed.
module bin_to_bcd_seq
  import display_pkg::*;
#(
  parameter int IN_W   = 5,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [IN_W-1:0]       value,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);

  logic [IN_W-1:0]       binSh;
  logic [BCD_W-1:0]      bcdSh;
  logic [BCD_W-1:0]      adj;
  logic [BCD_W+IN_W-1:0] shifted;
  logic [CNT_W-1:0]      cnt;
  logic                  running;
  logic                  doneQ;

  always_comb begin
    adj = bcdSh;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcdSh[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcdSh[4*i +: 4] + 4'd3;
    end
    shifted = {adj, binSh} << 1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      binSh   <= '0;
      bcdSh   <= '0;
      cnt     <= '0;
      running <= 1'b0;
      doneQ   <= 1'b0;
    end else begin
      doneQ <= 1'b0;
      if (start) begin
        binSh   <= value;
        bcdSh   <= '0;
        cnt     <= '0;
        running <= 1'b1;
      end else if (running) begin
        bcdSh <= shifted[BCD_W+IN_W-1:IN_W];
        binSh <= shifted[IN_W-1:0];
        cnt   <= cnt + 1'b1;
        if (cnt == CNT_W'(IN_W - 1)) begin
          running <= 1'b0;
          doneQ   <= 1'b1;
        end
      end
    end
  end

  assign done = doneQ;
  assign bcd  = bcdSh;

endmodule

// File: rtl/hex_display_controller.sv
// Score BCD display with leading-zero blanking plus a scrolling /
// blinking message field for the blackjack board.
module hex_display_controller
  import display_pkg::*;
#(
  parameter int HAND_W       = 5,
  parameter int SCORE_DIGITS = 2,
  parameter int MSG_DIGITS   = 4,
  parameter int TICK_DIV     = 25000000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [HAND_W-1:0]         player_value,
  input  logic [HAND_W-1:0]         dealer_value,
  input  gameState                  game_state,
  output logic [7*SCORE_DIGITS-1:0] hex_player,
  output logic [7*SCORE_DIGITS-1:0] hex_dealer,
  output logic [7*MSG_DIGITS-1:0]   hex_msg,
  output logic                      busy
);

  localparam int BCD_W    = 4 * SCORE_DIGITS;
  localparam int RING_LEN = TITLE_LEN + MSG_DIGITS;
  localparam int IDX_W    = $clog2(RING_LEN);
  localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam longint MAX_HAND = (longint'(1) << HAND_W) - 1;

  if (pow10(SCORE_DIGITS) <= MAX_HAND) begin : gBadDigits
    $error("SCORE_DIGITS too small for HAND_W");
  end
  if (MSG_DIGITS < 4) begin : gBadMsg
    $error("MSG_DIGITS must be at least 4");
  end

  // ---------------- score path ----------------
  logic [HAND_W-1:0]         snapPlayer, snapDealer;
  logic                      snapValid, busyQ, start;
  logic                      pDone, dDone;
  logic [BCD_W-1:0]          pBcd, dBcd;
  logic [7*SCORE_DIGITS-1:0] hexPlayerQ, hexDealerQ;

  function automatic logic [7*SCORE_DIGITS-1:0] scoreSegs(
    input logic [BCD_W-1:0] b
  );
    logic [7*SCORE_DIGITS-1:0] s;
    logic [3:0]                nib;
    logic                      lead;
    lead = 1'b1;
    s = '0;
    for (int i = SCORE_DIGITS - 1; i >= 0; i--) begin
      nib = b[4*i +: 4];
      if (nib != 4'd0 || i == 0) lead = 1'b0;
      s[7*i +: 7] = lead ? SEG_BLANK : sevenSegmentDecoder({2'b00, nib});
    end
    return s;
  endfunction

  always_comb begin
    start = !busyQ && (!snapValid ||
            player_value != snapPlayer ||
            dealer_value != snapDealer);
  end

  bin_to_bcd_seq #(.IN_W(HAND_W), .DIGITS(SCORE_DIGITS)) uPlayer (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .value (player_value),
    .done  (pDone),
    .bcd   (pBcd)
  );

  bin_to_bcd_seq #(.IN_W(HAND_W), .DIGITS(SCORE_DIGITS)) uDealer (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .value (dealer_value),
    .done  (dDone),
    .bcd   (dBcd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      snapPlayer <= '0;
      snapDealer <= '0;
      snapValid  <= 1'b0;
      busyQ      <= 1'b0;
      hexPlayerQ <= {SCORE_DIGITS{SEG_BLANK}};
      hexDealerQ <= {SCORE_DIGITS{SEG_BLANK}};
    end else if (start) begin
      snapPlayer <= player_value;
      snapDealer <= dealer_value;
      snapValid  <= 1'b1;
      busyQ      <= 1'b1;
    end else if (pDone && dDone) begin
      busyQ      <= 1'b0;
      hexPlayerQ <= scoreSegs(pBcd);
      hexDealerQ <= scoreSegs(dBcd);
    end
  end

  assign hex_player = hexPlayerQ;
  assign hex_dealer = hexDealerQ;
  assign busy       = busyQ;

  // ---------------- message path ----------------
  msg_mode_t                msgMode, modeNext;
  gameState                 lastState;
  logic [CNT_W-1:0]         tickCnt, cntNext;
  logic [IDX_W-1:0]         scrollIdx, idxNext;
  logic                     visible, visNext;
  logic                     tick, reentry;
  char_t [3:0]              blinkText;
  logic [7*MSG_DIGITS-1:0]  hexMsgQ, msgNext;

  always_comb begin
    modeNext = M_STATIC;
    unique case (1'b1)
      (game_state == S_RESET):       modeNext = M_SCROLL;
      (game_state == S_RESULT_WIN),
      (game_state == S_RESULT_LOSE),
      (game_state == S_RESULT_TIE):  modeNext = M_BLINK;
      default:                       modeNext = M_STATIC;
    endcase
  end

  // A hop between two result states restarts the blink as well.
  always_comb begin
    reentry = (modeNext != msgMode) ||
              (modeNext == M_BLINK && game_state != lastState);
    tick    = 1'b0;
    cntNext = tickCnt;
    idxNext = scrollIdx;
    visNext = visible;
    if (reentry) begin
      cntNext = '0;
      idxNext = '0;
      visNext = 1'b1;
    end else begin
      tick    = (tickCnt == CNT_W'(TICK_DIV - 1));
      cntNext = tick ? '0 : tickCnt + 1'b1;
      if (tick) begin
        idxNext = (scrollIdx == IDX_W'(RING_LEN - 1)) ?
                  '0 : scrollIdx + 1'b1;
        visNext = !visible;
      end
    end
  end

  always_comb begin
    int    r;
    char_t ch;
    unique case (game_state)
      S_RESULT_WIN:  blinkText = MSG_WIN;
      S_RESULT_LOSE: blinkText = MSG_LOSE;
      default:       blinkText = MSG_TIE;
    endcase
    msgNext = '0;
    for (int d = 0; d < MSG_DIGITS; d++) begin
      ch = CHAR_BLANK;
      r  = 0;
      case (modeNext)
        M_SCROLL: begin
          r = int'(idxNext) + (MSG_DIGITS - 1 - d);
          if (r >= RING_LEN) r = r - RING_LEN;
          ch = titleChar(r);
        end
        M_BLINK: begin
          if (visNext && d < 4) ch = blinkText[d];
        end
        default: begin
          if (d < 4) ch = MSG_PLAY[d];
        end
      endcase
      msgNext[7*d +: 7] = sevenSegmentDecoder(ch);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      msgMode   <= M_STATIC;
      lastState <= S_RESET;
      tickCnt   <= '0;
      scrollIdx <= '0;
      visible   <= 1'b1;
      hexMsgQ   <= {MSG_DIGITS{SEG_BLANK}};
    end else begin
      msgMode   <= modeNext;
      lastState <= game_state;
      tickCnt   <= cntNext;
      scrollIdx <= idxNext;
      visible   <= visNext;
      hexMsgQ   <= msgNext;
    end
  end

  assign hex_msg = hexMsgQ;

endmodule

// File: tb/tb_hex_display_controller.sv
// Directed bench for hex_display_controller: score conversion,
// blanking, scroll and blink timing with TICK_DIV=4.
module tb_hex_display_controller;
  import display_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  pv, dv;
  gameState    gs;
  logic [13:0] hexPlayer, hexDealer, hp6, hd6;
  logic [27:0] hexMsg;
  logic [41:0] hm6;
  logic        busy, busy6;

  int nVec = 0;
  int nErr = 0;

  always #5 clk = ~clk;

  hex_display_controller #(
    .HAND_W(5), .SCORE_DIGITS(2), .MSG_DIGITS(4), .TICK_DIV(4)
  ) dut (
    .clk(clk), .reset(reset),
    .player_value(pv), .dealer_value(dv), .game_state(gs),
    .hex_player(hexPlayer), .hex_dealer(hexDealer),
    .hex_msg(hexMsg), .busy(busy)
  );

  hex_display_controller #(
    .HAND_W(5), .SCORE_DIGITS(2), .MSG_DIGITS(6), .TICK_DIV(4)
  ) dut6 (
    .clk(clk), .reset(reset),
    .player_value(pv), .dealer_value(dv), .game_state(gs),
    .hex_player(hp6), .hex_dealer(hd6),
    .hex_msg(hm6), .busy(busy6)
  );

  function automatic logic [6:0] segOf(input byte c);
    case (c)
      "0": return 7'h40; "1": return 7'h79; "2": return 7'h24;
      "3": return 7'h30; "4": return 7'h19; "5": return 7'h12;
      "6": return 7'h02; "7": return 7'h78; "8": return 7'h00;
      "9": return 7'h10; "A": return 7'h08; "B": return 7'h03;
      "C": return 7'h46; "E": return 7'h06; "I": return 7'h4F;
      "J": return 7'h61; "K": return 7'h0A; "L": return 7'h47;
      "N": return 7'h2B; "O": return 7'h40; "P": return 7'h0C;
      "S": return 7'h12; "T": return 7'h07; "W": return 7'h55;
      "Y": return 7'h11;
      default: return 7'h7F;
    endcase
  endfunction

  // Leftmost character lands in the highest digit.
  function automatic logic [63:0] segStr(input string s);
    logic [63:0] v;
    int n;
    v = '0;
    n = s.len();
    for (int i = 0; i < n; i++) v[7*(n-1-i) +: 7] = segOf(s[i]);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; pv = 5'd0; dv = 5'd0; gs = S_DEAL;
    step(3);
    chk("rst_player", 64'(hexPlayer), segStr("  "));
    chk("rst_dealer", 64'(hexDealer), segStr("  "));
    chk("rst_msg",    64'(hexMsg),    segStr("    "));
    chk("rst_busy",   64'(busy),      64'd0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("busy_first", 64'(busy), 64'd1);
    end
    chk("hold_blank", 64'(hexPlayer), segStr("  "));
    step(1);
    chk("busy_done",   64'(busy),      64'd0);
    chk("player_zero", 64'(hexPlayer), segStr(" 0"));
    chk("dealer_zero", 64'(hexDealer), segStr(" 0"));
    chk("msg_play",    64'(hexMsg),    segStr("PLAY"));
    chk("p6_zero",     64'(hp6),       segStr(" 0"));
    chk("d6_zero",     64'(hd6),       segStr(" 0"));

    pv = 5'd21;
    step(1);
    chk("busy_21", 64'(busy), 64'd1);
    step(5);
    chk("no_glitch", 64'(hexPlayer), segStr(" 0"));
    step(1);
    chk("player_21",   64'(hexPlayer), segStr("21"));
    chk("dealer_hold", 64'(hexDealer), segStr(" 0"));

    pv = 5'd7; dv = 5'd10;
    step(7);
    chk("player_7",  64'(hexPlayer), segStr(" 7"));
    chk("dealer_10", 64'(hexDealer), segStr("10"));

    pv = 5'd12;
    step(2);
    pv = 5'd17;
    step(5);
    chk("player_12", 64'(hexPlayer), segStr("12"));
    chk("busy_12",   64'(busy),      64'd0);
    step(1);
    chk("busy_17",   64'(busy),      64'd1);
    chk("still_12",  64'(hexPlayer), segStr("12"));
    step(5);
    chk("late_12",   64'(hexPlayer), segStr("12"));
    step(1);
    chk("player_17", 64'(hexPlayer), segStr("17"));

    dv = 5'd31;
    step(7);
    chk("dealer_31", 64'(hexDealer), segStr("31"));

    gs = S_RESET;
    step(1);
    chk("scroll_0",  64'(hexMsg), segStr("BLAC"));
    step(3);
    chk("scroll_0b", 64'(hexMsg), segStr("BLAC"));
    step(1);
    chk("scroll_1",  64'(hexMsg), segStr("LACK"));
    step(4);
    chk("scroll_2",  64'(hexMsg), segStr("ACKJ"));
    step(40);
    chk("scroll_12", 64'(hexMsg), segStr(" BLA"));
    step(4);
    chk("scroll_wr", 64'(hexMsg), segStr("BLAC"));

    gs = S_RESULT_LOSE;
    step(1);
    chk("lose_on",   64'(hexMsg), segStr("LOSE"));
    step(3);
    chk("lose_on2",  64'(hexMsg), segStr("LOSE"));
    step(1);
    chk("lose_off",  64'(hexMsg), segStr("    "));
    step(3);
    chk("lose_off2", 64'(hexMsg), segStr("    "));
    step(1);
    chk("lose_on3",  64'(hexMsg), segStr("LOSE"));
    step(4);
    chk("lose_off3", 64'(hexMsg), segStr("    "));
    step(1);
    gs = S_RESULT_TIE;
    step(1);
    chk("tie_on",    64'(hexMsg), segStr(" TIE"));
    step(3);
    chk("tie_on2",   64'(hexMsg), segStr(" TIE"));
    step(1);
    chk("tie_off",   64'(hexMsg), segStr("    "));

    gs = S_RESULT_WIN;
    step(1);
    chk("win6_on",  64'(hm6),    segStr("   WIN"));
    chk("win4_on",  64'(hexMsg), segStr(" WIN"));
    step(4);
    chk("win6_off", 64'(hm6),    segStr("      "));
    step(1);
    reset = 1'b1;
    step(1);
    chk("rst_win6",   64'(hm6),       segStr("      "));
    chk("rst_score",  64'(hexPlayer), segStr("  "));
    chk("rst_busy2",  64'(busy),      64'd0);
    reset = 1'b0;
    step(1);
    chk("win6_again", 64'(hm6),   segStr("   WIN"));
    chk("busy6_rest", 64'(busy6), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
